// File: rtl/input_buffer_sequencer.sv
// Sequencer for the sliding-window input buffer: parallel row loads, serial
// shift-ins and window handshakes toward the PE array, with job config checks.
module input_buffer_sequencer #(
    parameter int N_DIM_ARRAY           = 16,
    parameter int MAXIMUM_DILATION_BITS = 3,
    parameter int COUNT_WIDTH           = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [2:0]                       mode,
    input  logic [MAXIMUM_DILATION_BITS-1:0] cfg_shift,
    input  logic [COUNT_WIDTH-1:0]           cfg_num_shifts,
    input  logic [COUNT_WIDTH-1:0]           cfg_num_rows,
    input  logic                             act_valid,
    output logic                             act_ready,
    input  logic                             array_ready,
    output logic                             clear,
    output logic                             loading_in_parallel,
    output logic                             enable,
    output logic [MAXIMUM_DILATION_BITS-1:0] shift_input_buffer,
    output logic                             compute_valid,
    output logic                             busy,
    output logic                             done,
    output logic                             cfg_error
);

    localparam logic [2:0] MODE_CNN = 3'd0;
    localparam logic [2:0] MODE_FC  = 3'd1;
    localparam logic [2:0] MODE_EWS = 3'd2;
    localparam int         SPAN_W   = MAXIMUM_DILATION_BITS + COUNT_WIDTH;

    typedef enum logic [2:0] {IDLE, CLR, LOAD, LWAIT, COMP, SHIFT, DONE} state_t;

    state_t                           state, state_nxt;
    logic [COUNT_WIDTH-1:0]           row_cnt, shift_cnt;
    logic [COUNT_WIDTH-1:0]           num_shifts_q;
    logic [MAXIMUM_DILATION_BITS-1:0] shift_q;
    logic [SPAN_W-1:0]                span;
    logic                             cnn_ok, start_reject;

    // Total pointer advance in one row must fit inside the buffer.
    assign span   = SPAN_W'(cfg_shift) * SPAN_W'(cfg_num_shifts);
    assign cnn_ok = (cfg_shift != '0) && (cfg_num_rows != '0) &&
                    (span <= SPAN_W'(N_DIM_ARRAY));
    assign start_reject = (state == IDLE) && start &&
                          !((mode == MODE_FC) || (mode == MODE_EWS) ||
                            ((mode == MODE_CNN) && cnn_ok));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (mode == MODE_FC || mode == MODE_EWS)
                        state_nxt = DONE;
                    else if (mode == MODE_CNN && cnn_ok)
                        state_nxt = CLR;
                end
            end
            CLR:   state_nxt = LOAD;
            LOAD:  if (act_valid) state_nxt = LWAIT;
            LWAIT: state_nxt = COMP;
            COMP: begin
                if (array_ready) begin
                    if (shift_cnt != '0)
                        state_nxt = SHIFT;
                    else if (row_cnt > COUNT_WIDTH'(1))
                        state_nxt = LOAD;
                    else
                        state_nxt = DONE;
                end
            end
            SHIFT: if (act_valid) state_nxt = COMP;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state              <= IDLE;
            row_cnt            <= '0;
            shift_cnt          <= '0;
            act_ready          <= 1'b0;
            clear              <= 1'b0;
            compute_valid      <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            cfg_error          <= 1'b0;
            shift_input_buffer <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == CLR)
                row_cnt <= cfg_num_rows;
            else if (state == COMP && array_ready && shift_cnt == '0 &&
                     row_cnt > COUNT_WIDTH'(1))
                row_cnt <= row_cnt - COUNT_WIDTH'(1);
            if (state == LWAIT)
                shift_cnt <= num_shifts_q;
            else if (state == SHIFT && act_valid)
                shift_cnt <= shift_cnt - COUNT_WIDTH'(1);
            act_ready     <= (state_nxt == LOAD) || (state_nxt == SHIFT);
            clear         <= (state_nxt == CLR);
            compute_valid <= (state_nxt == COMP);
            busy          <= (state_nxt != IDLE);
            done          <= (state_nxt == DONE);
            cfg_error     <= start_reject;
            if (state_nxt == IDLE)
                shift_input_buffer <= '0;
            else if (state == IDLE)
                shift_input_buffer <= cfg_shift;
            else
                shift_input_buffer <= shift_q;
        end
    end

    // Job configuration is data: captured on an accepted start, never reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            shift_q      <= cfg_shift;
            num_shifts_q <= cfg_num_shifts;
        end
    end

    assign loading_in_parallel = act_ready && act_valid && (state == LOAD);
    assign enable              = act_ready && act_valid && (state == SHIFT);

endmodule

// File: doc/input_buffer_sequencer.md
INPUT_BUFFER_SEQUENCER -- requirements
Module: input_buffer_sequencer

Interface
REQ-001 Parameter: N_DIM_ARRAY, 16, array width in activations (buffer depth).
REQ-002 Parameter: MAXIMUM_DILATION_BITS, 3, width of the per-shift element count.
REQ-003 Parameter: COUNT_WIDTH, 16, width of the row and shift counters.
REQ-004 Clocking: one clock; reset is synchronous and active-low.
REQ-005 Port: clk  in  1  clock; all state updates on the rising edge.
REQ-006 Port: reset  in  1  synchronous active-low reset.
REQ-007 Port: start  in  1  one-cycle job request; sampled only in IDLE.
REQ-008 Port: mode  in  3  layer type (MODE_CNN, MODE_FC, MODE_EWS); latched on start.
REQ-009 Port: cfg_shift  in  MAXIMUM_DILATION_BITS  elements shifted in per slide; latched on start.
REQ-010 Port: cfg_num_shifts  in  COUNT_WIDTH  slides per row after each parallel load; latched on start.
REQ-011 Port: cfg_num_rows  in  COUNT_WIDTH  parallel loads per job; latched on start.
REQ-012 Port: act_valid  in  1  activation source has parallel or serial data available.
REQ-013 Port: act_ready  out  1  controller consumes source data this cycle.
REQ-014 Port: array_ready  in  1  PE array accepts the current window.
REQ-015 Port: clear  out  1  clears the buffer FIFO and pointer.
REQ-016 Port: loading_in_parallel  out  1  parallel load request to the buffer.
REQ-017 Port: enable  out  1  serial shift-in strobe to the buffer.
REQ-018 Port: shift_input_buffer  out  MAXIMUM_DILATION_BITS  shift count to the buffer.
REQ-019 Port: compute_valid  out  1  buffer output holds a valid window.
REQ-020 Port: busy  out  1  high in every state except IDLE.
REQ-021 Port: done  out  1  one-cycle job completion pulse.
REQ-022 Port: cfg_error  out  1  one-cycle pulse when start is rejected.

Function
REQ-023 The FSM SHALL have the states IDLE, CLR, LOAD, LWAIT, COMP, SHIFT and DONE.
REQ-024 IDLE, start with mode FC or EWS: SHALL go to DONE; clear, loading_in_parallel and enable stay low (the buffer is pass-through in these modes).
REQ-025 IDLE, start with MODE_CNN: SHALL reject (cfg_error=1 next cycle, stay IDLE) if cfg_shift==0, cfg_num_rows==0, or cfg_shift*cfg_num_shifts > N_DIM_ARRAY.
REQ-026 IDLE, start with any other mode value: SHALL reject the same way.
REQ-027 An accepted CNN start SHALL load the row counter with cfg_num_rows and go to CLR.
REQ-028 CLR: clear=1 for exactly one cycle, then go to LOAD.
REQ-029 LOAD: act_ready=1 and loading_in_parallel=act_valid; on act_valid, go to LWAIT.
REQ-030 LWAIT: one cycle with all strobes low; the source SHALL hold the parallel data during this cycle; on exit, the shift counter loads cfg_num_shifts and the FSM goes to COMP.
REQ-031 COMP: compute_valid=1 until array_ready; on array_ready:
  - shifts remaining > 0: go to SHIFT;
  - otherwise, rows remaining > 1: decrement the row counter, go to LOAD (no clear);
  - otherwise: go to DONE.
REQ-032 SHIFT: act_ready=1 and enable=act_valid, with shift_input_buffer=latched cfg_shift; on act_valid, decrement the shift counter and go to COMP.
REQ-033 shift_input_buffer SHALL hold the latched cfg_shift whenever busy=1, and 0 otherwise.
REQ-034 Window latency: the first compute_valid SHALL occur 2 cycles after the load handshake, and 1 cycle after each shift handshake.
REQ-035 The controller SHALL issue no load or enable while compute_valid=1 and array_ready=0 (backpressure).
REQ-036 act_ready SHALL be 0 outside LOAD and SHIFT; act_valid is ignored there.
REQ-037 DONE: done=1 for one cycle, then go to IDLE.
REQ-038 A start during busy SHALL be ignored, with no error.
REQ-039 Windows per job SHALL equal cfg_num_rows*(cfg_num_shifts+1); cfg_num_shifts=0 gives one window per row.
REQ-040 The cumulative pointer advance per row SHALL never exceed N_DIM_ARRAY; this is guaranteed by REQ-025.

Reset
REQ-041 With reset=0 at a clock edge: state=IDLE, all counters 0, and every output 0 (act_ready, clear, loading_in_parallel, enable, shift_input_buffer, compute_valid, busy, done, cfg_error).
REQ-042 A reset asserted mid-job SHALL abort the job immediately with no done pulse; the next job starts with CLR.

Verification
REQ-043 CNN job, shift=2, num_shifts=3, rows=2, act_valid and array_ready held 1 -> clear 1 pulse, 2 loads, 6 enables, 8 compute_valid handshakes, then one done pulse.
REQ-044 Backpressure: array_ready=0 for 5 cycles in the first COMP -> compute_valid held 5 cycles, no enable and act_ready=0 meanwhile, then normal progress.
REQ-045 Source stall: act_valid=0 for 3 cycles in LOAD -> loading_in_parallel low for those cycles; first compute_valid exactly 2 cycles after act_valid rises.
REQ-046 Illegal config (N=16): shift=4, num_shifts=5 -> cfg_error for 1 cycle, busy stays 0; rows=0 -> same.
REQ-047 FC start -> done one cycle later, no clear, load or enable pulses; an undefined mode value -> cfg_error.
REQ-048 Reset asserted in SHIFT -> all outputs 0 the next cycle, no done; a subsequent valid start runs to completion.
